// File: rtl/param_ram_pkg.sv
// Shared definitions for the parameter RAM and its clear-sweep sequencer.
package param_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/param_ram_clr_seq.sv
// Clear-sweep sequencer: walks every address once after reset or a clear request.
//  state | meaning
//  IDLE  | normal read/write access, waiting for clear
//  CLEAR | zeroing mem[cnt] each edge, cnt counts 0..DEPTH-1
module param_ram_clr_seq
    import param_ram_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              busy,
    output logic [ADDR_W-1:0] swp_addr,
    output logic              swp_we
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              cnt_last;

    assign cnt_last = (cnt == {ADDR_W{1'b1}});

    // Reset parks the sequencer in CLEAR so memory is always swept after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state == CLEAR);
        swp_we   = (state == CLEAR);
        swp_addr = cnt;
    end

endmodule

// File: rtl/param_ram.sv
// Single-port parameter RAM with write-first registered read and a hardware zero sweep.
module param_ram #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] sel,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy,
    output logic              load_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] swp_addr;
    logic              swp_we;
    logic              wr_en;

    param_ram_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .busy     (busy),
        .swp_addr (swp_addr),
        .swp_we   (swp_we)
    );

    assign wr_en = load & ~busy & rst_n;

    always_ff @(posedge clk) begin
        if (swp_we) begin
            mem[swp_addr] <= '0;
        end else if (wr_en) begin
            mem[sel] <= in;
        end
    end

    // A clear request forces 0 on the entry edge so out is already 0 once CLEAR is visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            load_drop <= 1'b0;
        end else begin
            load_drop <= busy & load;
            if (busy || clear) begin
                out <= '0;
            end else if (load) begin
                out <= in;
            end else begin
                out <= mem[sel];
            end
        end
    end

endmodule

// File: tb/tb_param_ram.sv
// Directed bench: small (ADDR_W=4) instance for sweep timing, default instance for addressing.
module tb_param_ram;

    logic        clk;
    logic        rst_n;

    logic [15:0] s_in, s_out;
    logic        s_load, s_clear, s_busy, s_drop;
    logic [3:0]  s_sel;

    logic [15:0] b_in, b_out;
    logic        b_load, b_clear, b_busy, b_drop;
    logic [11:0] b_sel;

    int errors = 0;
    int checks = 0;
    int n;

    param_ram #(.WIDTH(16), .ADDR_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .in(s_in), .load(s_load), .sel(s_sel),
        .clear(s_clear), .out(s_out), .busy(s_busy), .load_drop(s_drop)
    );

    param_ram #(.WIDTH(16), .ADDR_W(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(b_in), .load(b_load), .sel(b_sel),
        .clear(b_clear), .out(b_out), .busy(b_busy), .load_drop(b_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s_in = '0; s_load = 1'b0; s_sel = '0; s_clear = 1'b0;
        b_in = '0; b_load = 1'b0; b_sel = '0; b_clear = 1'b0;
        repeat (3) tick();

        check("rst_s_busy", 32'(s_busy), 32'd1);
        check("rst_s_out",  32'(s_out),  32'd0);
        check("rst_s_drop", 32'(s_drop), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd1);
        check("rst_b_out",  32'(b_out),  32'd0);

        rst_n = 1'b1;
        n = 0;
        while (s_busy && n < 100) begin
            tick();
            n++;
        end
        check("rst_sweep_len", 32'(n), 32'd16);

        for (int i = 0; i < 16; i++) begin
            s_sel = 4'(i);
            tick();
            check("post_rst_read0", 32'(s_out), 32'd0);
        end

        n = 0;
        while (b_busy && n < 5000) begin
            tick();
            n++;
        end
        check("b_sweep_done", 32'(b_busy), 32'd0);

        b_load = 1'b1; b_in = 16'hF00D; b_sel = 12'h958;
        tick();
        check("wr_first_f00d", 32'(b_out), 32'hF00D);
        b_load = 1'b0;
        tick();
        check("rd_f00d", 32'(b_out), 32'hF00D);
        b_sel = 12'h02B;
        tick();
        check("rd_02b_zero", 32'(b_out), 32'd0);

        b_load = 1'b1; b_in = 16'hDEAF;
        tick();
        check("wr_first_deaf", 32'(b_out), 32'hDEAF);
        b_load = 1'b0;
        tick();
        check("rd_deaf", 32'(b_out), 32'hDEAF);
        b_sel = 12'h958;
        tick();
        check("rd_f00d_again", 32'(b_out), 32'hF00D);

        b_load = 1'b1; b_in = 16'hFFFF; b_sel = 12'hFFF;
        tick();
        b_load = 1'b0; b_sel = 12'h000;
        tick();
        check("rd_addr0_untouched", 32'(b_out), 32'd0);
        b_sel = 12'hFFF;
        tick();
        check("rd_top_ffff", 32'(b_out), 32'hFFFF);

        // Clear sweep on the large instance; a load and a second clear arrive mid-sweep.
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        n = 0;
        check("clr_busy_enter", 32'(b_busy), 32'd1);
        check("clr_out_zero",   32'(b_out),  32'd0);
        tick(); n++;
        tick(); n++;
        b_load = 1'b1; b_in = 16'h1234; b_sel = 12'h958;
        tick(); n++;
        b_load = 1'b0;
        check("drop_pulse", 32'(b_drop), 32'd1);
        check("clr_out_hold0", 32'(b_out), 32'd0);
        tick(); n++;
        check("drop_one_cycle", 32'(b_drop), 32'd0);
        b_clear = 1'b1;
        tick(); n++;
        b_clear = 1'b0;
        while (b_busy && n < 10000) begin
            tick();
            n++;
        end
        check("clr_sweep_len", 32'(n), 32'd4096);
        b_sel = 12'h958;
        tick();
        check("clr_958_zero", 32'(b_out), 32'd0);
        b_sel = 12'h02B;
        tick();
        check("clr_02b_zero", 32'(b_out), 32'd0);
        b_sel = 12'hFFF;
        tick();
        check("clr_fff_zero", 32'(b_out), 32'd0);

        // Small instance: write, clear with simultaneous load, reset mid-sweep at cnt=7.
        s_load = 1'b1; s_in = 16'hABCD; s_sel = 4'd3;
        tick();
        s_load = 1'b0;
        tick();
        check("s_rd_abcd", 32'(s_out), 32'hABCD);
        s_load = 1'b1; s_in = 16'h7777; s_sel = 4'd5; s_clear = 1'b1;
        tick();
        s_load = 1'b0; s_clear = 1'b0;
        check("s_clr_busy", 32'(s_busy), 32'd1);
        check("s_clr_load_no_drop", 32'(s_drop), 32'd0);
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midsweep_rst_busy", 32'(s_busy), 32'd1);
        n = 0;
        while (s_busy && n < 100) begin
            tick();
            n++;
        end
        check("midsweep_restart_len", 32'(n), 32'd16);
        s_sel = 4'd3;
        tick();
        check("s_3_zero", 32'(s_out), 32'd0);
        s_sel = 4'd5;
        tick();
        check("s_5_zero", 32'(s_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
